spi_slave_core: RTL and testbench

- Slave-side endpoint of the APB SPI link; the other end of the master's baud-rate and SCLK logic.
- Oversamples external SCLK/SS_n/MOSI on PCLK and detects SCLK edges per CPOL/CPHA.
- Samples MOSI into a receive shift register and drives MISO from a transmit shift register backed by a one-entry transmit buffer.
- Presents completed bytes to the register/APB side with a valid pulse.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_slave_if.sv | 35 +++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_slave_core.sv | 176 +++++++++++++++++
 tb/tb_spi_slave_core.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave core and the master's mode decode.
package spi_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Encoded as {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    // Transmitted when a frame starts with an empty transmit buffer
    localparam logic [63:0] UNDERRUN_FILL = '1;

    function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin and register-side signal bundle of the SPI slave endpoint.
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  spi_en;
    logic                  cpol;
    logic                  cpha;
    logic                  lsbfe;
    logic                  ss_n;
    logic                  sclk_in;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_abort;
    logic                  busy;

    modport slave (
        input  spi_en, cpol, cpha, lsbfe, ss_n, sclk_in, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

    modport master (
        output spi_en, cpol, cpha, lsbfe, ss_n, sclk_in, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous input with registered rise/fall strobes;
// o_level is the registered copy, so it already shows the new level while a strobe is high.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= {SYNC_STAGES{RESET_VAL}};
            r_level <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_level <= w_sync;
            r_rise  <= w_sync & ~r_level;
            r_fall  <= ~w_sync & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: oversampled pins, rx/tx shift registers, one-entry tx buffer.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    spi_slave_if.slave bus
);

    localparam int unsigned         CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] FILL   = UNDERRUN_FILL[DATA_WIDTH-1:0];

    spi_state_e             r_state;
    spi_mode_e              r_mode;
    logic                   r_lsbfe;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_buf;
    logic                   r_buf_full;
    logic                   r_rx_valid;
    logic                   r_underrun;
    logic                   r_abort;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_cpol, w_cpha, w_active, w_mosi;
    logic w_sclk_edge, w_lead, w_trail;
    logic w_sample, w_shift, w_last, w_load, w_shift_tx, w_capture, w_partial;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] w_tx_next;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_async (bus.sclk_in),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_async (bus.ss_n),
        .o_level (w_ss_lvl),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cpol   = r_mode[1];
    assign w_cpha   = r_mode[0];
    assign w_active = (r_state == ACTIVE);

    // Strobes arrive with the new level, so leading means "now away from cpol"
    assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
    assign w_lead      = w_sclk_edge & (w_sclk_lvl != w_cpol);
    assign w_trail     = w_sclk_edge & (w_sclk_lvl == w_cpol);
    assign w_sample    = w_active & (w_cpha ? w_trail : w_lead);
    assign w_shift     = w_active & (w_cpha ? w_lead : w_trail);
    assign w_last      = w_sample & (r_bit_cnt == LAST_BIT);

    // bit_cnt==0 on a shift edge marks a frame boundary in both phases
    assign w_load     = (~w_active & w_ss_fall & ~w_cpha) | (w_shift & (r_bit_cnt == '0));
    assign w_shift_tx = w_shift & (r_bit_cnt != '0);
    assign w_capture  = bus.tx_valid & ~r_buf_full;
    assign w_partial  = ((r_bit_cnt != '0) | w_sample) & ~w_last;

    assign w_rx_next = r_lsbfe ? {w_mosi, r_rx_shift[DATA_WIDTH-1:1]}
                               : {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
    assign w_tx_next = r_lsbfe ? {1'b0, r_tx_shift[DATA_WIDTH-1:1]}
                               : {r_tx_shift[DATA_WIDTH-2:0], 1'b0};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mode  <= MODE0;
            r_lsbfe <= 1'b0;
        end else if (!w_active) begin
            r_mode  <= spi_mode(bus.cpol, bus.cpha);
            r_lsbfe <= bus.lsbfe;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_abort    <= 1'b0;
            if (!bus.spi_en) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (!w_active) begin
                if (w_ss_fall) begin
                    r_state    <= ACTIVE;
                    r_bit_cnt  <= '0;
                    r_rx_shift <= '0;
                end
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (w_last) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                if (w_ss_rise) begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    r_abort   <= w_partial;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx_shift <= '0;
            r_tx_buf   <= '0;
            r_buf_full <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!bus.spi_en) begin
                r_tx_shift <= '0;
                r_buf_full <= 1'b0;
            end else begin
                if (w_load) begin
                    r_tx_shift <= r_buf_full ? r_tx_buf : FILL;
                    r_underrun <= ~r_buf_full;
                end else if (w_shift_tx) begin
                    r_tx_shift <= w_tx_next;
                end
                if (w_capture) begin
                    r_tx_buf <= bus.tx_data;
                end
                // A same-cycle load sees the old (empty) buffer; the new byte still lands
                r_buf_full <= w_capture | (r_buf_full & ~w_load);
            end
        end
    end

    assign bus.miso        = r_lsbfe ? r_tx_shift[0] : r_tx_shift[DATA_WIDTH-1];
    assign bus.miso_oe     = bus.spi_en & ~w_ss_lvl;
    assign bus.tx_ready    = ~r_buf_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_underrun;
    assign bus.frame_abort = r_abort;
    assign bus.busy        = w_active;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: drives the SPI pins as a master at 4 PCLK per SCLK half-period.
module tb_spi_slave_core;

    localparam int HALF = 40;

    logic pclk;
    logic presetn;

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;
    int abt_cnt = 0;
    int s_rxv, s_und, s_abt;

    logic m_cpol, m_cpha, m_lsb;
    logic [7:0] got_a, got_b;

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (bus.rx_valid)    rxv_cnt++;
        if (bus.tx_underrun) und_cnt++;
        if (bus.frame_abort) abt_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_rxv = rxv_cnt;
        s_und = und_cnt;
        s_abt = abt_cnt;
    endtask

    function automatic logic pick(input logic [7:0] d, input int i);
        return m_lsb ? d[i] : d[7-i];
    endfunction

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        @(negedge pclk);
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
        bus.cpol = cpol; bus.cpha = cpha; bus.lsbfe = lsb;
        bus.sclk_in = cpol;
        repeat (8) @(negedge pclk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge pclk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge pclk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic ss_low();
        @(negedge pclk);
        bus.ss_n = 1'b0;
        repeat (8) @(negedge pclk);
    endtask

    task automatic ss_high();
        repeat (4) @(negedge pclk);
        bus.ss_n = 1'b1;
        repeat (8) @(negedge pclk);
    endtask

    // Master shifts nbits of tx out on MOSI and collects MISO into rx
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic [7:0] r;
        r = 8'h00;
        if (!m_cpha) begin
            bus.mosi = pick(tx, 0);
            #(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            if (m_cpha) begin
                bus.sclk_in = ~m_cpol;
                bus.mosi    = pick(tx, i);
                #(HALF);
                if (m_lsb) r[i] = bus.miso; else r[7-i] = bus.miso;
                bus.sclk_in = m_cpol;
                #(HALF);
            end else begin
                if (m_lsb) r[i] = bus.miso; else r[7-i] = bus.miso;
                bus.sclk_in = ~m_cpol;
                #(HALF);
                bus.sclk_in = m_cpol;
                if (i < nbits - 1) bus.mosi = pick(tx, i + 1);
                #(HALF);
            end
        end
        rx = r;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},     bus.miso,        1'b0);
        check_eq({tag, "_miso_oe"},  bus.miso_oe,     1'b0);
        check_eq({tag, "_tx_ready"}, bus.tx_ready,    1'b1);
        check_eq({tag, "_rx_data"},  bus.rx_data,     8'h00);
        check_eq({tag, "_rx_valid"}, bus.rx_valid,    1'b0);
        check_eq({tag, "_underrun"}, bus.tx_underrun, 1'b0);
        check_eq({tag, "_abort"},    bus.frame_abort, 1'b0);
        check_eq({tag, "_busy"},     bus.busy,        1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        presetn = 1'b1;
        bus.spi_en = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsbfe = 1'b0;
        bus.ss_n = 1'b1; bus.sclk_in = 1'b0; bus.mosi = 1'b0;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        #3 presetn = 1'b0;
        #4 check_reset_outputs("rst");
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        bus.spi_en = 1'b1;

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(8'hA5);
        check_eq("m0_tx_ready_full", bus.tx_ready, 1'b0);
        snap();
        ss_low();
        check_eq("m0_tx_ready_after_ss", bus.tx_ready, 1'b1);
        check_eq("m0_busy", bus.busy, 1'b1);
        check_eq("m0_miso_oe", bus.miso_oe, 1'b1);
        xfer(8'h3C, 8, got_a);
        ss_high();
        check_eq("m0_rx_data", bus.rx_data, 8'h3C);
        check_eq("m0_master_rx", got_a, 8'hA5);
        check_eq("m0_rx_valid_cnt", rxv_cnt - s_rxv, 1);
        check_eq("m0_abort_cnt", abt_cnt - s_abt, 0);
        check_eq("m0_busy_end", bus.busy, 1'b0);

        // Mode 3, LSB first, back-to-back frames
        set_mode(1'b1, 1'b1, 1'b1);
        tx_write(8'h81);
        snap();
        ss_low();
        xfer(8'h12, 8, got_a);
        check_eq("m3_rx_data_f1", bus.rx_data, 8'h12);
        tx_write(8'h7E);
        xfer(8'h34, 8, got_b);
        ss_high();
        check_eq("m3_master_rx_f1", got_a, 8'h81);
        check_eq("m3_master_rx_f2", got_b, 8'h7E);
        check_eq("m3_rx_data_f2", bus.rx_data, 8'h34);
        check_eq("m3_rx_valid_cnt", rxv_cnt - s_rxv, 2);
        check_eq("m3_underrun_cnt", und_cnt - s_und, 0);

        // Mode 1, empty buffer
        set_mode(1'b0, 1'b1, 1'b0);
        snap();
        ss_low();
        xfer(8'h5A, 8, got_a);
        ss_high();
        check_eq("m1_master_rx", got_a, 8'hFF);
        check_eq("m1_underrun_cnt", und_cnt - s_und, 1);
        check_eq("m1_rx_data", bus.rx_data, 8'h5A);
        check_eq("m1_rx_valid_cnt", rxv_cnt - s_rxv, 1);

        // Mode 2, abort after 5 bits, then a full frame
        set_mode(1'b1, 1'b0, 1'b0);
        snap();
        ss_low();
        xfer(8'hF0, 5, got_a);
        ss_high();
        check_eq("m2_abort_cnt", abt_cnt - s_abt, 1);
        check_eq("m2_abort_rx_valid_cnt", rxv_cnt - s_rxv, 0);
        check_eq("m2_abort_rx_data", bus.rx_data, 8'h5A);
        check_eq("m2_abort_busy", bus.busy, 1'b0);
        snap();
        ss_low();
        xfer(8'hC3, 8, got_a);
        ss_high();
        check_eq("m2_rx_data", bus.rx_data, 8'hC3);
        check_eq("m2_rx_valid_cnt", rxv_cnt - s_rxv, 1);
        check_eq("m2_full_abort_cnt", abt_cnt - s_abt, 0);

        // spi_en dropped mid-frame
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(8'h3C);
        snap();
        ss_low();
        tx_write(8'h11);
        check_eq("en_tx_ready_full", bus.tx_ready, 1'b0);
        xfer(8'h55, 3, got_a);
        @(negedge pclk);
        bus.spi_en = 1'b0;
        @(negedge pclk);
        check_eq("en_busy", bus.busy, 1'b0);
        check_eq("en_tx_ready", bus.tx_ready, 1'b1);
        check_eq("en_miso", bus.miso, 1'b0);
        check_eq("en_miso_oe", bus.miso_oe, 1'b0);
        ss_high();
        check_eq("en_abort_cnt", abt_cnt - s_abt, 0);
        check_eq("en_rx_valid_cnt", rxv_cnt - s_rxv, 0);
        check_eq("en_rx_data_held", bus.rx_data, 8'hC3);
        @(negedge pclk);
        bus.spi_en = 1'b1;
        repeat (4) @(negedge pclk);
        snap();
        ss_low();
        xfer(8'h96, 8, got_a);
        ss_high();
        check_eq("en_rx_data", bus.rx_data, 8'h96);
        check_eq("en_rx_valid_after", rxv_cnt - s_rxv, 1);

        // Asynchronous reset during bit 3
        ss_low();
        xfer(8'h24, 3, got_a);
        #3 presetn = 1'b0;
        #1 check_reset_outputs("mid_rst");
        bus.ss_n = 1'b1;
        bus.sclk_in = 1'b0;
        repeat (4) @(negedge pclk);
        presetn = 1'b1;
        repeat (8) @(negedge pclk);
        snap();
        ss_low();
        xfer(8'hE7, 8, got_a);
        ss_high();
        check_eq("rec_rx_data", bus.rx_data, 8'hE7);
        check_eq("rec_rx_valid_cnt", rxv_cnt - s_rxv, 1);
        check_eq("rec_abort_cnt", abt_cnt - s_abt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
